// File: rtl/pixel_stream_packer_pkg.sv
// Shared types and helpers for the pixel stream packer: FSM states, default
// sync byte, CRC-8 (poly 0x07) step and frame length.
package pixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_SEQ,
    ST_DATA,
    ST_CSUM
  } packer_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic int unsigned frame_len(input logic [15:0] mask, input int unsigned bytes_per_pixel);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) n++;
    end
    return 3 + n * bytes_per_pixel;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_fifo.sv
// Single-clock FIFO; rd_data is a registered copy of the head entry, valid from
// the second cycle after the FIFO becomes non-empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             addi_clk,
  input  logic             nRST,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_reg;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = head_reg;

  always_ff @(posedge addi_clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset so it maps onto RAM primitives.
  always_ff @(posedge addi_clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
    head_reg <= mem[rd_ptr_reg];
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Gathers one pixel word per enabled channel and emits SYNC/SEQ/DATA/CSUM frames.
// Define PIXEL_STREAM_PACKER_CRC8_EN to replace the XOR checksum with CRC-8.
module pixel_stream_packer
  import pixel_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         PIXEL_W    = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                      addi_clk,
  input  logic                      nRST,
  input  logic [NUM_CH-1:0]         pix_valid,
  input  logic [NUM_CH*PIXEL_W-1:0] pix_data,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic                      overflow_clr,
  output logic [7:0]                byte_data,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic [NUM_CH-1:0]         overflow,
  output logic                      busy
);

  localparam int BPP  = PIXEL_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW   = (BPP > 1) ? $clog2(BPP) : 1;

  if (PIXEL_W < 8 || (PIXEL_W % 8) != 0) begin : g_bad_pixel_w
    $error("pixel_stream_packer: PIXEL_W must be a multiple of 8 and >= 8");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("pixel_stream_packer: NUM_CH must be 1..16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pixel_stream_packer: FIFO_DEPTH must be a power of 2, >= 2");
  end

  packer_state_e      state_reg, state_next;
  logic [7:0]         seq_reg, csum_reg, csum_step;
  logic [NUM_CH-1:0]  en_q_reg, overflow_reg;
  logic [PIXEL_W-1:0] shadow_reg [NUM_CH];
  logic [PIXEL_W-1:0] fifo_rd [NUM_CH];
  logic [CH_W-1:0]    ch_idx_reg, first_ch, next_ch;
  logic [BW-1:0]      byte_idx_reg;
  logic [NUM_CH-1:0]  fifo_full, fifo_empty, fifo_pop, ovf_set;
  logic               next_found, last_byte, frame_ready, xfer;
  logic [PIXEL_W-1:0] cur_word;
  logic [7:0]         cur_byte;

  // Disabled channels are held flushed so stale words never enter a later frame.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    sync_fifo #(.WIDTH(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .addi_clk (addi_clk),
      .nRST     (nRST),
      .flush    (~ch_enable[gi]),
      .push     (pix_valid[gi] & ch_enable[gi]),
      .pop      (fifo_pop[gi]),
      .wr_data  (pix_data[gi*PIXEL_W +: PIXEL_W]),
      .rd_data  (fifo_rd[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  assign fifo_pop    = (state_reg == ST_LOAD) ? ch_enable : '0;
  assign ovf_set     = pix_valid & ch_enable & fifo_full & ~fifo_pop;
  assign frame_ready = (|ch_enable) && ((~fifo_empty & ch_enable) == ch_enable);
  assign overflow    = overflow_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign xfer        = byte_valid & byte_ready;
  assign cur_word    = shadow_reg[ch_idx_reg];
  assign last_byte   = (byte_idx_reg == BW'(BPP - 1));

`ifdef PIXEL_STREAM_PACKER_CRC8_EN
  assign csum_step = crc8_update(csum_reg, byte_data);
`else
  assign csum_step = csum_reg ^ byte_data;
`endif

  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    cur_byte   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_ch = CH_W'(i);
      if (en_q_reg[i] && i > int'(ch_idx_reg)) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
    // byte_idx 0 selects the most significant byte.
    for (int b = 0; b < BPP; b++) begin
      if (byte_idx_reg == BW'(BPP - 1 - b)) cur_byte = cur_word[b*8 +: 8];
    end
  end

  always_comb begin
    state_next = state_reg;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state_reg)
      ST_IDLE: if (frame_ready) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SYNC;
      ST_SYNC: begin
        byte_valid = 1'b1;
        byte_data  = SYNC_BYTE;
        if (byte_ready) state_next = ST_SEQ;
      end
      ST_SEQ: begin
        byte_valid = 1'b1;
        byte_data  = seq_reg;
        if (byte_ready) state_next = ST_DATA;
      end
      ST_DATA: begin
        byte_valid = 1'b1;
        byte_data  = cur_byte;
        if (byte_ready && last_byte && !next_found) state_next = ST_CSUM;
      end
      ST_CSUM: begin
        byte_valid = 1'b1;
        byte_data  = csum_reg;
        if (byte_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge addi_clk or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= ST_IDLE;
      seq_reg      <= '0;
      csum_reg     <= '0;
      en_q_reg     <= '0;
      ch_idx_reg   <= '0;
      byte_idx_reg <= '0;
      overflow_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_reg[i] <= '0;
    end else begin
      state_reg    <= state_next;
      overflow_reg <= ovf_set | (overflow_reg & ~{NUM_CH{overflow_clr}});
      case (state_reg)
        ST_LOAD: begin
          en_q_reg     <= ch_enable;
          csum_reg     <= '0;
          ch_idx_reg   <= first_ch;
          byte_idx_reg <= '0;
          for (int i = 0; i < NUM_CH; i++) shadow_reg[i] <= fifo_rd[i];
        end
        ST_SEQ: if (xfer) csum_reg <= csum_step;
        ST_DATA: begin
          if (xfer) begin
            csum_reg <= csum_step;
            if (last_byte) begin
              byte_idx_reg <= '0;
              if (next_found) ch_idx_reg <= next_ch;
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
            end
          end
        end
        ST_CSUM: if (xfer) seq_reg <= seq_reg + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
